// File: rtl/router_pkg.sv
// Shared definitions for the router output arbiter: FSM states, header field
// position, default stall timeout and round-robin helpers.
package router_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_RD,
    HDR_WAIT,
    BODY,
    DRAIN
  } state_t;

  localparam int unsigned NUM_PORTS       = 3;
  localparam int unsigned LEN_MSB         = 7;
  localparam int unsigned LEN_LSB         = 2;
  localparam int unsigned LEN_W           = LEN_MSB - LEN_LSB + 1;
  localparam int unsigned STALL_LIMIT_DEF = 30;

  // Port index p advanced by off, modulo the port count.
  function automatic logic [1:0] port_wrap(input logic [1:0] p, input int unsigned off);
    int unsigned s;
    s = {30'd0, p} + off;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return 2'(s);
  endfunction

  // First requesting port at or after start, wrapping around.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] start);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = start;
    for (int unsigned k = NUM_PORTS; k > 0; k--) begin
      idx = port_wrap(start, k - 1);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

  function automatic logic [2:0] port_onehot(input logic [1:0] p);
    return 3'b001 << p;
  endfunction

endpackage

// File: rtl/router_skid_buf.sv
// Two-entry in-order output buffer feeding the link; head entry drives the
// output and only moves on a pop, so data holds while the link stalls.
module router_skid_buf #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;

  // Shift-style storage: head is the oldest byte, tail the next one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else               tail <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign data = head;

endmodule

// File: rtl/router_out_arb.sv
// Output-link arbiter: round-robin picks one of three FIFOs, streams a whole
// packet (header, payload, parity) through a 2-entry buffer, aborts a packet
// whose FIFO starves for STALL_LIMIT cycles.
module router_out_arb
  import router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned STALL_LIMIT = STALL_LIMIT_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2:0]            fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout_0,
  input  logic [DATA_WIDTH-1:0] fifo_dout_1,
  input  logic [DATA_WIDTH-1:0] fifo_dout_2,
  output logic [2:0]            read_enb,
  output logic [2:0]            soft_reset,
  output logic [2:0]            grant,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  pkt_done
);

  localparam int unsigned RW = LEN_W + 1;
  localparam int unsigned SW = $clog2(STALL_LIMIT + 1);
  localparam logic [RW-1:0] ONE_R     = RW'(1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT);

  state_t          state, state_d;
  logic [2:0]      grant_q, grant_d;
  logic [1:0]      port_q, port_d;
  logic [1:0]      rr_q, rr_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic            abort_q, abort_d;
  logic            rd_pend_q;

  logic [1:0]            buf_count;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  pop;
  logic [2:0]            occ;
  logic                  credit;
  logic                  sel_empty;
  logic [DATA_WIDTH-1:0] sel_dout;
  logic [RW-1:0]         hdr_total;

  router_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clock     (clock),
    .reset     (reset),
    .push      (rd_pend_q),
    .pop       (pop),
    .push_data (sel_dout),
    .count     (buf_count),
    .data      (buf_data)
  );

  assign out_valid = (buf_count != 2'd0);
  assign out_data  = buf_data;
  assign pop       = out_valid & out_ready;
  assign grant     = grant_q;

  // A byte leaving this cycle frees its slot in time for a new read, which
  // is what sustains one byte per cycle with the link always ready.
  assign occ    = {1'b0, buf_count} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign credit = (occ < 3'd2);

  assign sel_empty = |(fifo_empty & grant_q);
  assign hdr_total = {1'b0, sel_dout[LEN_MSB:LEN_LSB]} + ONE_R;

  // Read data of the currently granted FIFO.
  always_comb begin
    case (port_q)
      2'd1:    sel_dout = fifo_dout_1;
      2'd2:    sel_dout = fifo_dout_2;
      default: sel_dout = fifo_dout_0;
    endcase
  end

  // Next-state, strobes and packet bookkeeping.
  always_comb begin
    state_d    = state;
    grant_d    = grant_q;
    port_d     = port_q;
    rr_d       = rr_q;
    rem_d      = rem_q;
    stall_d    = '0;
    abort_d    = abort_q;
    read_enb   = '0;
    soft_reset = '0;
    pkt_done   = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_empty != 3'b111) begin
          port_d  = rr_pick(~fifo_empty, rr_q);
          grant_d = port_onehot(port_d);
          state_d = HDR_RD;
        end
      end
      HDR_RD: begin
        if (!sel_empty && credit) begin
          read_enb = grant_q;
          state_d  = HDR_WAIT;
        end
      end
      HDR_WAIT: begin
        // The header is on fifo_dout now; length+1 is always >= 1, so the
        // first post-header read is issued here to avoid a bubble.
        rem_d = hdr_total;
        if (!sel_empty && credit) begin
          read_enb = grant_q;
          rem_d    = hdr_total - ONE_R;
        end
        state_d = (rem_d == '0) ? DRAIN : BODY;
      end
      BODY: begin
        if (stall_q == STALL_MAX) begin
          soft_reset = grant_q;
          abort_d    = 1'b1;
          rem_d      = '0;
          state_d    = DRAIN;
        end else if (rem_q == '0) begin
          state_d = DRAIN;
        end else if (sel_empty) begin
          stall_d = stall_q + SW'(1);
        end else if (credit) begin
          read_enb = grant_q;
          rem_d    = rem_q - ONE_R;
          if (rem_q == ONE_R) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!rd_pend_q && ((buf_count == 2'd0) || ((buf_count == 2'd1) && pop))) begin
          pkt_done = !abort_q && (buf_count == 2'd1);
          grant_d  = '0;
          rr_d     = port_wrap(port_q, 1);
          abort_d  = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and bookkeeping registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant_q   <= '0;
      port_q    <= '0;
      rr_q      <= '0;
      rem_q     <= '0;
      stall_q   <= '0;
      abort_q   <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state     <= state_d;
      grant_q   <= grant_d;
      port_q    <= port_d;
      rr_q      <= rr_d;
      rem_q     <= rem_d;
      stall_q   <= stall_d;
      abort_q   <= abort_d;
      rd_pend_q <= |read_enb;
    end
  end

endmodule
